uart_frame_parser: RTL
======================

Name: uart_frame_parser

Overview:
- Receive-side counterpart to the 9-byte detection-report UART sender.
- Consumes the byte stream from the UART RX path, one byte per rx_valid strobe.
- Reassembles the bounding box (x_min, x_max, y_min, y_max) and the traffic status byte, validates them, and presents them as registered outputs with a one-cycle frame_valid strobe.
- Feeds the downstream display/overlay and the violation logger; uses inter-byte idle timeout for frame resynchronisation because the frame has no header.

Parameters:
TIMEOUT_CYCLES, 200000, idle clk cycles between bytes in a partial frame before it is discarded; legal range >= 1.

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
rx_valid  input  1  one-cycle strobe: rx_data holds a newly received byte
rx_data  input  8  received byte
x_min  output  16  committed bounding-box left edge
x_max  output  16  committed right edge
y_min  output  16  committed top edge
y_max  output  16  committed bottom edge
traffic_light  output  1  0=green, 1=red
human_violation  output  2  0 none, 1 caution, 2 violation
car_violation  output  1  0 none, 1 violation
traffic_amount  output  2  0 low, 1 medium, 2 high
frame_valid  output  1  one-cycle strobe: outputs just updated from a good frame
frame_err  output  1  one-cycle strobe: frame discarded (timeout or check failure)
busy  output  1  high while a partial frame is held (COLLECT or CHECK)
good_count  output  16  count of accepted frames, wraps 0xFFFF->0
err_count  output  8  count of discarded frames, saturates at 0xFF

Behaviour:
- Frame order, MSB byte first:
  - bytes 0-1 x_min, 2-3 x_max, 4-5 y_min, 6-7 y_max.
  - byte 8 status: [7] traffic_light, [6:5] human_violation, [4] car_violation, [3:2] traffic_amount, [1:0] reserved.
- Reset: every output 0; state IDLE; byte index 0; timeout counter 0; shadow registers 0.
- FSM states:
  - IDLE: on rx_valid, store byte 0 in shadow, index=1, clear timeout counter, go to COLLECT.
  - COLLECT: on rx_valid, store the byte at the current index and increment the index. The byte at index 8 stores the status byte and moves to CHECK.
  - COLLECT timeout: with no rx_valid, the timeout counter increments. When it reaches TIMEOUT_CYCLES-1, the next edge discards the partial frame: frame_err pulses, err_count increments, index=0, go to IDLE.
  - CHECK: one cycle. The frame is good when the reserved bits are 00, human_violation != 3 and traffic_amount != 3.
    - Good: at the CHECK exit edge, all field outputs load from shadow, frame_valid pulses, good_count increments.
    - Bad: frame_err pulses, err_count increments, field outputs hold.
  - CHECK exit target: IDLE, or COLLECT if rx_valid is high during CHECK.
- Latency: 9th byte's rx_valid in cycle k -> fields updated and frame_valid high in cycle k+2.
- rx_valid during CHECK: that byte is taken as byte 0 of the next frame (index=1, COLLECT); no byte is ever dropped.
- rx_valid in the same cycle the timeout counter hits terminal count: the byte wins, the counter clears, no timeout.
- Timeout counter width: $clog2(TIMEOUT_CYCLES+1). It is idle (held 0) outside COLLECT.
- Field outputs change only on a good-frame commit; partial or bad frames never disturb them.
- frame_valid and frame_err are never high in the same cycle.
- Reset asserted mid-frame: partial data is discarded and all outputs return to 0 on that edge.
- busy = (state != IDLE), registered.

Optional Feature:
BBOX_CHECK_EN: when defined, CHECK also requires x_min <= x_max and y_min <= y_max (unsigned 16-bit compare); a violation is a bad frame (frame_err, fields hold). When undefined, no geometric check is made and such frames are accepted as-is.

Test Plan:
- Good frame:
  - Stimulus: bytes 00 10 00 9F 00 20 00 77 D4, gaps of 50 cycles.
  - Response: x_min=0x0010, x_max=0x009F, y_min=0x0020, y_max=0x0077, traffic_light=1, human_violation=2, car_violation=1, traffic_amount=1; frame_valid exactly in cycle k+2 after the 9th strobe; good_count=1.
- Timeout resync (TIMEOUT_CYCLES=100):
  - Stimulus: 4 bytes, then 100 idle cycles, then the good frame above.
  - Response: one frame_err, err_count=1, fields still 0 after the timeout; then the good frame parses correctly.
- Bad status:
  - Stimulus: good frame with byte 8 = D5 (reserved bit set); repeat with byte 8 = 0x60 (human_violation=3).
  - Response: frame_err each time, err_count +2, fields unchanged, no frame_valid.
- Back-to-back frames:
  - Stimulus: byte 0 of frame 2 strobed in the CHECK cycle of frame 1; frame 2 = 01 00 01 40 00 00 00 F0 00.
  - Response: both frame_valid pulses; final x_min=0x0100, x_max=0x0140, y_max=0x00F0; good_count=2.
- Reset mid-frame:
  - Stimulus: reset after 5 bytes of a frame, then a full good frame.
  - Response: all outputs 0 and busy=0 after reset; next frame accepted, good_count=1.
- BBOX check:
  - Stimulus: frame with x_min=0x0100, x_max=0x0050, status 00.
  - Response with BBOX_CHECK_EN: frame_err, fields hold.
  - Response without BBOX_CHECK_EN: frame_valid, x_min=0x0100, x_max=0x0050.

Source files
------------

// File: rtl/uart_frame_parser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_frame_parser                                             |
// | Purpose  : Receive-side parser for the 9-byte detection report.          |
// |            Reassembles the bounding box (x_min, x_max, y_min, y_max)     |
// |            and the traffic status byte from a UART RX byte stream,       |
// |            validates the frame and commits it to registered outputs.     |
// |            The frame has no header, so an inter-byte idle timeout is     |
// |            the only resynchronisation mechanism.                         |
// | Optional : define BBOX_CHECK_EN to also reject frames whose box is       |
// |            inverted (x_min > x_max or y_min > y_max, unsigned).          |
// | Ports    :                                                               |
// |   clk             in   1  system clock, rising edge                      |
// |   reset           in   1  synchronous active-high reset                  |
// |   rx_valid        in   1  strobe: rx_data holds a new byte               |
// |   rx_data         in   8  received byte                                  |
// |   x_min/x_max     out 16  committed horizontal box edges                 |
// |   y_min/y_max     out 16  committed vertical box edges                   |
// |   traffic_light   out  1  0 green, 1 red                                 |
// |   human_violation out  2  0 none, 1 caution, 2 violation                 |
// |   car_violation   out  1  0 none, 1 violation                            |
// |   traffic_amount  out  2  0 low, 1 medium, 2 high                        |
// |   frame_valid     out  1  strobe: fields just updated from a good frame  |
// |   frame_err       out  1  strobe: frame discarded (timeout or check)     |
// |   busy            out  1  a partial frame is held                        |
// |   good_count      out 16  accepted frames, wrapping                      |
// |   err_count       out  8  discarded frames, saturating                   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module uart_frame_parser #(
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [15:0] x_min,
  output logic [15:0] x_max,
  output logic [15:0] y_min,
  output logic [15:0] y_max,
  output logic        traffic_light,
  output logic [1:0]  human_violation,
  output logic        car_violation,
  output logic [1:0]  traffic_amount,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        busy,
  output logic [15:0] good_count,
  output logic [7:0]  err_count
);

  localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam int              NBYTES   = 9;
  localparam logic [3:0]      IDX_LAST = 4'd8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_CHECK   = 2'd2;

  // State and datapath registers
  logic [1:0]       state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       shadow_q [NBYTES];
  logic [7:0]       shadow_d [NBYTES];

  logic [15:0] x_min_q, x_min_d;
  logic [15:0] x_max_q, x_max_d;
  logic [15:0] y_min_q, y_min_d;
  logic [15:0] y_max_q, y_max_d;
  logic        tl_q, tl_d;
  logic [1:0]  hv_q, hv_d;
  logic        cv_q, cv_d;
  logic [1:0]  ta_q, ta_d;
  logic        fv_q, fv_d;
  logic        fe_q, fe_d;
  logic        busy_q, busy_d;
  logic [15:0] good_cnt_q, good_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  // Assembled view of the shadow frame (byte 0 is the MSB of x_min)
  logic [15:0] w_sx_min, w_sx_max, w_sy_min, w_sy_max;
  logic [7:0]  w_status;
  logic        w_status_ok;
  logic        w_geom_ok;
  logic        w_frame_ok;
  logic [7:0]  w_err_cnt_inc;

  assign w_sx_min = {shadow_q[0], shadow_q[1]};
  assign w_sx_max = {shadow_q[2], shadow_q[3]};
  assign w_sy_min = {shadow_q[4], shadow_q[5]};
  assign w_sy_max = {shadow_q[6], shadow_q[7]};
  assign w_status = shadow_q[8];

  // Reserved bits must be clear and the two 2-bit enums must not use code 3
  assign w_status_ok = (w_status[1:0] == 2'b00) &&
                       (w_status[6:5] != 2'b11) &&
                       (w_status[3:2] != 2'b11);

`ifdef BBOX_CHECK_EN
  assign w_geom_ok = (w_sx_min <= w_sx_max) && (w_sy_min <= w_sy_max);
`else
  assign w_geom_ok = 1'b1;
`endif

  assign w_frame_ok = w_status_ok && w_geom_ok;

  // err_count sticks at 0xFF instead of wrapping
  assign w_err_cnt_inc = (err_cnt_q == 8'hFF) ? err_cnt_q : (err_cnt_q + 8'd1);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q;
    for (int i = 0; i < NBYTES; i++) begin
      shadow_d[i] = shadow_q[i];
    end
    x_min_d    = x_min_q;
    x_max_d    = x_max_q;
    y_min_d    = y_min_q;
    y_max_d    = y_max_q;
    tl_d       = tl_q;
    hv_d       = hv_q;
    cv_d       = cv_q;
    ta_d       = ta_q;
    fv_d       = 1'b0;
    fe_d       = 1'b0;
    good_cnt_d = good_cnt_q;
    err_cnt_d  = err_cnt_q;

    case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (rx_valid) begin
          shadow_d[0] = rx_data;
          idx_d       = 4'd1;
          state_d     = ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        if (rx_valid) begin
          // A byte arriving on the terminal count still wins over the timeout
          for (int i = 0; i < NBYTES; i++) begin
            if (idx_q == 4'(i)) begin
              shadow_d[i] = rx_data;
            end
          end
          tmo_d = '0;
          if (idx_q == IDX_LAST) begin
            idx_d   = 4'd0;
            state_d = ST_CHECK;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else if (tmo_q == TMO_LAST) begin
          fe_d      = 1'b1;
          err_cnt_d = w_err_cnt_inc;
          idx_d     = 4'd0;
          tmo_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      ST_CHECK: begin
        tmo_d = '0;
        if (w_frame_ok) begin
          x_min_d    = w_sx_min;
          x_max_d    = w_sx_max;
          y_min_d    = w_sy_min;
          y_max_d    = w_sy_max;
          tl_d       = w_status[7];
          hv_d       = w_status[6:5];
          cv_d       = w_status[4];
          ta_d       = w_status[3:2];
          fv_d       = 1'b1;
          good_cnt_d = good_cnt_q + 16'd1;
        end else begin
          fe_d      = 1'b1;
          err_cnt_d = w_err_cnt_inc;
        end
        // The commit above reads the old shadow, so byte 0 of the next
        // frame can be captured on this same edge without loss.
        if (rx_valid) begin
          shadow_d[0] = rx_data;
          idx_d       = 4'd1;
          state_d     = ST_COLLECT;
        end else begin
          idx_d   = 4'd0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        idx_d   = 4'd0;
        tmo_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= 4'd0;
      tmo_q      <= '0;
      for (int i = 0; i < NBYTES; i++) begin
        shadow_q[i] <= 8'h00;
      end
      x_min_q    <= 16'h0000;
      x_max_q    <= 16'h0000;
      y_min_q    <= 16'h0000;
      y_max_q    <= 16'h0000;
      tl_q       <= 1'b0;
      hv_q       <= 2'b00;
      cv_q       <= 1'b0;
      ta_q       <= 2'b00;
      fv_q       <= 1'b0;
      fe_q       <= 1'b0;
      busy_q     <= 1'b0;
      good_cnt_q <= 16'h0000;
      err_cnt_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      for (int i = 0; i < NBYTES; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
      x_min_q    <= x_min_d;
      x_max_q    <= x_max_d;
      y_min_q    <= y_min_d;
      y_max_q    <= y_max_d;
      tl_q       <= tl_d;
      hv_q       <= hv_d;
      cv_q       <= cv_d;
      ta_q       <= ta_d;
      fv_q       <= fv_d;
      fe_q       <= fe_d;
      busy_q     <= busy_d;
      good_cnt_q <= good_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign x_min           = x_min_q;
  assign x_max           = x_max_q;
  assign y_min           = y_min_q;
  assign y_max           = y_max_q;
  assign traffic_light   = tl_q;
  assign human_violation = hv_q;
  assign car_violation   = cv_q;
  assign traffic_amount  = ta_q;
  assign frame_valid     = fv_q;
  assign frame_err       = fe_q;
  assign busy            = busy_q;
  assign good_count      = good_cnt_q;
  assign err_count       = err_cnt_q;

endmodule
`default_nettype wire
